// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer arbiter bus bundle.
// Groups the display read port, drawer write handshake, clear-engine control,
// stall counter and the single-port RAM connection.
//   slave  : the arbiter side (vga_fb_arbiter)
//   master : the surrounding logic (display fetch, drawer, clear control, RAM)
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
);
  // display fetch
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  // drawer write handshake
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  // clear engine control
  logic              clear_start;
  logic [DATA_W-1:0] clear_data;
  logic              clear_busy;
  // framebuffer RAM
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  // diagnostics
  logic [15:0]       stall_cnt;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           clear_start, clear_data, mem_rdata,
    output disp_data, disp_valid, wr_ready, clear_busy,
           mem_addr, mem_wdata, mem_we, stall_cnt
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           clear_start, clear_data, mem_rdata,
    input  disp_data, disp_valid, wr_ready, clear_busy,
           mem_addr, mem_wdata, mem_we, stall_cnt
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter for the VGA path.
// Shares one synchronous-read RAM between the display fetch (absolute
// priority), a built-in full-buffer clear engine and a valid/ready drawer.
// Ports:
//   clk - system clock
//   clr - asynchronous active-high reset
//   bus - vga_fb_arbiter_if.slave: display read port (2-clock latency),
//         drawer write handshake, clear control/busy, RAM port, stall count
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FB_DEPTH = 19200
) (
  input logic           clk,
  input logic           clr,
  vga_fb_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FB_DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_oob_q, rd_oob_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [15:0]       stall_q, stall_d;

  logic              disp_in_range;
  logic              wr_in_range;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    color_d      = color_q;
    stall_d      = stall_q;

    disp_in_range = bus.disp_addr < DEPTH_A;
    wr_in_range   = bus.wr_addr < DEPTH_A;

    bus.wr_ready  = !clr && !bus.disp_req && (state_q == ST_IDLE);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;

    // Read pipeline: stage 1 tracks the request while the RAM reads,
    // stage 2 registers the returned pixel (or 0 for an out-of-range address).
    rd_pend_d    = bus.disp_req;
    rd_oob_d     = !disp_in_range;
    disp_valid_d = rd_pend_q;
    disp_data_d  = disp_data_q;
    if (rd_pend_q) begin
      disp_data_d = rd_oob_q ? '0 : bus.mem_rdata;
    end

    if (bus.disp_req) begin
      if (disp_in_range) begin
        bus.mem_addr = bus.disp_addr;
      end
    end else if (state_q == ST_CLEAR) begin
      bus.mem_addr  = ptr_q;
      bus.mem_wdata = color_q;
      bus.mem_we    = 1'b1;
      ptr_d         = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST_A) begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    end else if (bus.wr_valid && bus.wr_ready) begin
      // Out-of-range writes still complete the handshake but never reach RAM.
      if (wr_in_range) begin
        bus.mem_addr  = bus.wr_addr;
        bus.mem_wdata = bus.wr_data;
        bus.mem_we    = 1'b1;
      end
    end

    if ((state_q == ST_IDLE) && bus.clear_start) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
      color_d = bus.clear_data;
    end

    if (bus.wr_valid && !bus.wr_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    if (clr) begin
      bus.mem_we = 1'b0;
    end

    // Idle cycles re-drive the last address so the RAM port stays quiet.
    addr_d = bus.mem_addr;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      color_q      <= '0;
      addr_q       <= '0;
      rd_pend_q    <= 1'b0;
      rd_oob_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      color_q      <= color_d;
      addr_q       <= addr_d;
      rd_pend_q    <= rd_pend_d;
      rd_oob_q     <= rd_oob_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.clear_busy = (state_q == ST_CLEAR);
  assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a behavioural synchronous RAM
// and a scoreboard of expected display returns (data and arrival cycle).
module tb_vga_fb_arbiter;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 19200;

  logic clk = 1'b0;
  logic clr = 1'b0;

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif)
  );

  always #10 clk = ~clk;

  logic [7:0] ram   [0:32767];
  logic [7:0] model [0:DEPTH-1];

  always @(posedge clk) begin
    if (bif.mem_we) ram[bif.mem_addr] <= bif.mem_wdata;
    bif.mem_rdata <= ram[bif.mem_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard monitor: every display return must match the oldest
  // expectation both in data and in arrival cycle.
  always @(negedge clk) begin
    if (bif.disp_valid === 1'b1) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL disp_unexpected: disp_valid=1 data=%h at cycle %0d, required no return", bif.disp_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bif.disp_data !== mon_e.data || cyc != mon_e.due)
          $display("FAIL disp_return: got data=%h cycle=%0d, required data=%h cycle=%0d", bif.disp_data, cyc, mon_e.data, mon_e.due);
        else pass_cnt++;
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      total_cnt++;
      mon_e = sb.pop_front();
      $display("FAIL disp_missing: no disp_valid at cycle %0d, required data=%h", cyc, mon_e.data);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [AW-1:0] addr, input logic [7:0] exp_data);
    exp_t e;
    bif.disp_req  = 1'b1;
    bif.disp_addr = addr;
    e.due  = cyc + 2;
    e.data = exp_data;
    sb.push_back(e);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    bif.wr_valid = 1'b1;
    bif.wr_addr  = 15'd3;
    bif.wr_data  = 8'h11;
    #2 clr = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (bif.disp_valid !== 1'b0 || bif.disp_data !== 8'h00) $display("FAIL reset_disp: valid=%b data=%h, required 0/00", bif.disp_valid, bif.disp_data);
    else pass_cnt++;
    total_cnt++;
    if (bif.clear_busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bif.clear_busy);
    else pass_cnt++;
    total_cnt++;
    if (bif.stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d required 0", bif.stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bif.mem_we !== 1'b0 || bif.wr_ready !== 1'b0) $display("FAIL reset_we_ready: mem_we=%b wr_ready=%b, required 0/0", bif.mem_we, bif.wr_ready);
    else pass_cnt++;
    next_cycle();
    clr = 1'b0;
    bif.wr_valid = 1'b0;
    next_cycle();
    issue_read(15'd5, 8'hE3);
    next_cycle();
    bif.disp_req = 1'b0;
    drain();
  endtask

  task automatic test_write_stall();
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      bif.wr_valid = 1'b1;
      bif.wr_addr  = 15'd100;
      bif.wr_data  = 8'h1C;
      if (c % 2 == 0) issue_read(15'd100, model[100]);
      else bif.disp_req = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bif.wr_ready !== (c % 2 != 0)) $display("FAIL wr_ready_c%0d: got %b required %b", c, bif.wr_ready, (c % 2 != 0));
      else pass_cnt++;
      if (c % 2 != 0) model[100] = 8'h1C;
    end
    next_cycle();
    bif.wr_valid = 1'b0;
    bif.disp_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bif.stall_cnt !== 16'd4) $display("FAIL stall_cnt: got %0d required 4", bif.stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (ram[100] !== 8'h1C) $display("FAIL ram100: got %h required 1c", ram[100]);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_oob();
    next_cycle();
    bif.wr_valid = 1'b1;
    bif.wr_addr  = 15'd19200;
    bif.wr_data  = 8'h77;
    @(negedge clk);
    total_cnt++;
    if (bif.wr_ready !== 1'b1 || bif.mem_we !== 1'b0) $display("FAIL oob_write: wr_ready=%b mem_we=%b, required 1/0", bif.wr_ready, bif.mem_we);
    else pass_cnt++;
    next_cycle();
    bif.wr_valid = 1'b0;
    issue_read(15'd19300, 8'h00);
    @(negedge clk);
    total_cnt++;
    if (bif.mem_we !== 1'b0) $display("FAIL oob_read_we: got %b required 0", bif.mem_we);
    else pass_cnt++;
    next_cycle();
    bif.disp_req = 1'b0;
    drain();
  endtask

  task automatic test_clear_quiet();
    int n = 0;
    int bad_ready = 0;
    int bad_mem = 0;
    next_cycle();
    bif.clear_start = 1'b1;
    bif.clear_data  = 8'h03;
    @(negedge clk);
    total_cnt++;
    if (bif.clear_busy !== 1'b0) $display("FAIL clear_busy_start: got %b required 0", bif.clear_busy);
    else pass_cnt++;
    next_cycle();
    bif.clear_start = 1'b0;
    for (int i = 0; i < 20001; i++) begin
      if (bif.clear_busy !== 1'b1) break;
      n++;
      @(negedge clk);
      if (bif.wr_ready !== 1'b0) bad_ready++;
      next_cycle();
    end
    total_cnt++;
    if (n != 19200) $display("FAIL clear_quiet_len: got %0d busy cycles required 19200", n);
    else pass_cnt++;
    total_cnt++;
    if (bad_ready != 0) $display("FAIL clear_wr_ready: got %0d cycles with wr_ready=1 required 0", bad_ready);
    else pass_cnt++;
    for (int a = 0; a < int'(DEPTH); a++) begin
      if (ram[a] !== 8'h03) bad_mem++;
      model[a] = 8'h03;
    end
    total_cnt++;
    if (bad_mem != 0) $display("FAIL clear_quiet_fill: got %0d wrong locations required 0", bad_mem);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_clear_with_display();
    int n = 0;
    int bad_mem = 0;
    next_cycle();
    bif.clear_start = 1'b1;
    bif.clear_data  = 8'h3C;
    next_cycle();
    bif.clear_start = 1'b0;
    for (int j = 0; j < 40001; j++) begin
      if (bif.clear_busy !== 1'b1) break;
      n++;
      bif.clear_start = (j == 1000);
      bif.clear_data  = (j == 1000) ? 8'hFF : 8'h3C;
      if (j % 2 == 0) issue_read(15'd19199, model[19199]);
      else bif.disp_req = 1'b0;
      next_cycle();
    end
    bif.disp_req    = 1'b0;
    bif.clear_start = 1'b0;
    total_cnt++;
    if (n < 38399 || n > 38401) $display("FAIL clear_disp_len: got %0d busy cycles required 38400+-1", n);
    else pass_cnt++;
    drain();
    for (int a = 0; a < int'(DEPTH); a++) begin
      if (ram[a] !== 8'h3C) bad_mem++;
      model[a] = 8'h3C;
    end
    total_cnt++;
    if (bad_mem != 0) $display("FAIL clear_disp_fill: got %0d locations not 3c required 0", bad_mem);
    else pass_cnt++;
  endtask

  task automatic test_clear_abort();
    int bad_mem = 0;
    next_cycle();
    bif.clear_start = 1'b1;
    bif.clear_data  = 8'h55;
    next_cycle();
    bif.clear_start = 1'b0;
    for (int i = 0; i < 5000; i++) next_cycle();
    total_cnt++;
    if (bif.clear_busy !== 1'b1) $display("FAIL abort_busy_before: got %b required 1", bif.clear_busy);
    else pass_cnt++;
    clr = 1'b1;
    #1;
    total_cnt++;
    if (bif.clear_busy !== 1'b0 || bif.mem_we !== 1'b0) $display("FAIL abort_immediate: busy=%b mem_we=%b, required 0/0", bif.clear_busy, bif.mem_we);
    else pass_cnt++;
    next_cycle();
    next_cycle();
    clr = 1'b0;
    for (int a = 0; a < 5000; a++) if (ram[a] !== 8'h55) bad_mem++;
    total_cnt++;
    if (bad_mem != 0) $display("FAIL abort_filled: got %0d wrong locations in 0..4999 required 0", bad_mem);
    else pass_cnt++;
    total_cnt++;
    if (ram[5000] !== model[5000]) $display("FAIL abort_ram5000: got %h required %h", ram[5000], model[5000]);
    else pass_cnt++;
    for (int a = 0; a < 5000; a++) model[a] = 8'h55;
    drain();
  endtask

  task automatic test_squash();
    int seen = 0;
    next_cycle();
    bif.disp_req  = 1'b1;
    bif.disp_addr = 15'd7;
    next_cycle();
    bif.disp_req = 1'b0;
    clr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bif.disp_valid !== 1'b0) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL squash: got %0d cycles with disp_valid=1 required 0", seen);
    else pass_cnt++;
    next_cycle();
    clr = 1'b0;
    next_cycle();
    issue_read(15'd7, model[7]);
    next_cycle();
    bif.disp_req = 1'b0;
    drain();
  endtask

  initial begin
    bif.disp_req    = 1'b0;
    bif.disp_addr   = '0;
    bif.wr_valid    = 1'b0;
    bif.wr_addr     = '0;
    bif.wr_data     = '0;
    bif.clear_start = 1'b0;
    bif.clear_data  = '0;
    for (int i = 0; i < 32768; i++) ram[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'(i) ^ 8'hA5;
    ram[5]   = 8'hE3;
    model[5] = 8'hE3;

    test_reset();
    test_write_stall();
    test_oob();
    test_clear_quiet();
    test_clear_with_display();
    test_clear_abort();
    test_squash();

    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_empty: got %0d outstanding returns required 0", sb.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter for the VGA path. It shares one synchronous-read RAM between three clients:
- the display fetch, which has absolute priority;
- a built-in clear engine that fills the whole buffer with one colour;
- a drawing client on a valid/ready handshake.

It sits between the pixel-fetch logic of `vga_top` and the framebuffer RAM, and returns 8-bit RGB332 pixels to the display side.

## Interface
- `ADDR_W`, 15, framebuffer address width
- `DATA_W`, 8, pixel width (RGB332: R[7:5], G[4:2], B[1:0])
- `FB_DEPTH`, 19200, number of valid pixel locations (160x120)

- `clk`  in  1  system clock, 50 MHz
- `clr`  in  1  reset, asynchronous, active-high
- `disp_req`  in  1  display read request this cycle
- `disp_addr`  in  ADDR_W  display read address
- `disp_data`  out  DATA_W  returned pixel
- `disp_valid`  out  1  `disp_data` valid (one-cycle pulse per request)
- `wr_valid`  in  1  drawer write request
- `wr_addr`  in  ADDR_W  drawer write address
- `wr_data`  in  DATA_W  drawer write pixel
- `wr_ready`  out  1  drawer write accepted this cycle
- `clear_start`  in  1  start full-buffer fill
- `clear_data`  in  DATA_W  fill colour, sampled on accepted `clear_start`
- `clear_busy`  out  1  fill in progress
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_we`  out  1  RAM write enable
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after address
- `stall_cnt`  out  16  saturating count of cycles with `wr_valid`=1 and `wr_ready`=0

## Operation
- Per-cycle grant, fixed priority:
  - display read if `disp_req`;
  - else clear write if state CLEAR;
  - else drawer write if `wr_valid`.
- `mem_addr`, `mem_wdata` and `mem_we` are combinational from the grant.
  - With no grant: `mem_we`=0 and `mem_addr` holds its last driven value.
- `wr_ready` = !`clr` && !`disp_req` && state==IDLE. It is combinational and independent of `wr_valid`.
  - A transfer occurs when `wr_valid` && `wr_ready`.
- Out-of-range `wr_addr` (>= `FB_DEPTH`): the handshake completes and `mem_we` is suppressed.
- Out-of-range `disp_addr`: no RAM access; `disp_data`=0 is returned with normal latency.
- State machine IDLE/CLEAR:
  - IDLE -> CLEAR on `clear_start`=1. This latches `clear_data`, sets ptr=0 and sets `clear_busy`=1 the next cycle.
  - In CLEAR, each cycle without `disp_req` writes `clear_data` at ptr, then ptr++.
  - The write at ptr==`FB_DEPTH`-1 returns the state to IDLE; `clear_busy` drops the following cycle.
  - `clear_start` during CLEAR is ignored; the latched colour is unchanged.
- Display cycles steal from the clear engine. The fill takes `FB_DEPTH` + (display cycles during fill) clocks.
- `stall_cnt` increments while `wr_valid`=1 and `wr_ready`=0, and saturates at 0xFFFF. Only `clr` clears it.

## Timing
- Reset values (`clr`=1, asynchronous):
  - `disp_valid`=0, `disp_data`=0, `clear_busy`=0, `stall_cnt`=0;
  - state IDLE, ptr=0;
  - combinational `mem_we`=0 and `wr_ready`=0 while `clr` is high.
- Display read latency is 2 clocks:
  - request at edge N;
  - RAM address driven in cycle N;
  - `mem_rdata` available in cycle N+1 and registered;
  - `disp_valid`=1 with data in cycle N+2.
- Back-to-back `disp_req` every cycle is supported at one pixel per clock. Typical use is every 2nd clock (25 MHz pixel rate).
- Drawer write takes effect in the RAM on the accepting edge. There is no write buffering; the drawer holds its signals until `wr_ready`.
- Read-after-write ordering follows grant cycles: a display read granted after a write cycle returns the new data.
- Simultaneous `clear_start` and `wr_valid` in IDLE: the drawer write is accepted that cycle if there is no `disp_req`. CLEAR starts next cycle.
- `clr` mid-clear aborts the fill with the buffer partially written.
- `clr` with a read in flight: the pending `disp_valid` is squashed.

## Test plan
- Reset, then `disp_req` at addr 5 with RAM[5]=0xE3 -> `disp_valid`=1 with `disp_data`=0xE3 exactly 2 cycles later; all outputs 0 during `clr`.
- `wr_valid` held with addr 100 / data 0x1C while `disp_req` pulses every other cycle -> `wr_ready` only in non-request cycles; RAM[100]=0x1C after one transfer; `stall_cnt` = number of blocked cycles.
- `clear_start` with `clear_data`=0x03 and no display traffic -> `clear_busy` high for exactly 19200 cycles; all locations read 0x03; `wr_ready`=0 throughout.
- Clear with `disp_req` every 2nd cycle -> fill completes in 38400±1 cycles; display reads keep 2-cycle latency; second `clear_start`=0xFF mid-fill is ignored.
- `wr_addr`=19200 with `wr_valid` -> handshake completes, `mem_we`=0; `disp_addr`=19300 -> `disp_data`=0.
- `clr` asserted at clear ptr 5000 -> `clear_busy`=0 immediately; RAM[0..4999] hold the fill colour; RAM[5000] is unchanged.
